waveform_generator_axis: RTL and testbench

//  Paced test-signal source feeding dac_ad5541a over AXI-stream.

---
 rtl/waveform_generator_axis.sv | 95 +++++++++
 tb/tb_waveform_generator_axis.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/waveform_generator_axis.sv
// Paced waveform source (saw/triangle/square/const) for the AXI-stream DAC path.
// One sample per RATE_DIV enabled clocks into a 1-deep register; backpressure drops samples and flags overrun.
module waveform_generator_axis #(
   parameter int unsigned RATE_DIV    = 1000,
   parameter int unsigned PHASE_WIDTH = 24
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [1:0]             mode,
   input  logic [PHASE_WIDTH-1:0] phase_inc,
   input  logic [15:0]            const_level,
   input  logic                   clr_overrun,
   output logic                   m_axis_valid,
   input  logic                   s_axis_ready,
   output logic [15:0]            m_axis_data,
   output logic                   overrun
);

   localparam int unsigned CNT_W   = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATE_DIV - 1);

   typedef enum logic [1:0] {
      MODE_SAW   = 2'b00,
      MODE_TRI   = 2'b01,
      MODE_SQ    = 2'b10,
      MODE_CONST = 2'b11
   } mode_e;

   logic [CNT_W-1:0]       div_cnt, div_cnt_nxt;
   logic [PHASE_WIDTH-1:0] phase, phase_nxt;
   logic                   valid_nxt;
   logic [15:0]            data_nxt;
   logic                   overrun_nxt;
   logic                   tick_c;
   logic [15:0]            p_c;
   logic [15:0]            sample_c;

   // Pacer: counter is held at zero while disabled, so a re-enable restarts the full period
   always_comb begin
      tick_c      = en && (div_cnt == CNT_MAX);
      div_cnt_nxt = '0;
      if (en && !tick_c) div_cnt_nxt = div_cnt + CNT_W'(1);
   end

   // Waveform mapper on the top 16 phase bits (value before this tick's update)
   always_comb begin
      p_c      = phase[PHASE_WIDTH-1 -: 16];
      sample_c = p_c;
      case (mode_e'(mode))
         MODE_SAW:   sample_c = p_c;
         MODE_TRI:   sample_c = p_c[15] ? ~{p_c[14:0], 1'b0} : {p_c[14:0], 1'b0};
         MODE_SQ:    sample_c = p_c[15] ? 16'h0000 : 16'hFFFF;
         MODE_CONST: sample_c = const_level;
         default:    sample_c = p_c;
      endcase
   end

   // Output slot: a tick loads only if the slot is empty or draining this cycle, otherwise it is dropped
   always_comb begin
      phase_nxt   = phase;
      valid_nxt   = m_axis_valid;
      data_nxt    = m_axis_data;
      overrun_nxt = overrun;
      if (clr_overrun) overrun_nxt = 1'b0;
      if (tick_c) begin
         phase_nxt = phase + phase_inc;
         if (!m_axis_valid || s_axis_ready) begin
            valid_nxt = 1'b1;
            data_nxt  = sample_c;
         end else begin
            overrun_nxt = 1'b1;
         end
      end else if (m_axis_valid && s_axis_ready) begin
         valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt      <= '0;
         phase        <= '0;
         m_axis_valid <= 1'b0;
         m_axis_data  <= '0;
         overrun      <= 1'b0;
      end else begin
         div_cnt      <= div_cnt_nxt;
         phase        <= phase_nxt;
         m_axis_valid <= valid_nxt;
         m_axis_data  <= data_nxt;
         overrun      <= overrun_nxt;
      end
   end

endmodule

// File: tb/tb_waveform_generator_axis.sv
// Bench for waveform_generator_axis: RATE_DIV=4 and RATE_DIV=1 instances share stimulus,
// checked against a sample-slot model plus directed waveform and corner-case sequences.
module tb_waveform_generator_axis;

   logic        clk = 1'b0;
   logic        rst, en, clr_overrun, ready;
   logic [1:0]  mode;
   logic [23:0] phase_inc;
   logic [15:0] const_level;
   logic        v0, v1, o0, o1;
   logic [15:0] d0, d1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   waveform_generator_axis #(.RATE_DIV(4), .PHASE_WIDTH(24)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .phase_inc(phase_inc),
      .const_level(const_level), .clr_overrun(clr_overrun), .m_axis_valid(v0),
      .s_axis_ready(ready), .m_axis_data(d0), .overrun(o0));

   waveform_generator_axis #(.RATE_DIV(1), .PHASE_WIDTH(24)) dut_full (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .phase_inc(phase_inc),
      .const_level(const_level), .clr_overrun(clr_overrun), .m_axis_valid(v1),
      .s_axis_ready(ready), .m_axis_data(d1), .overrun(o1));

   // Reference: each instance is a sample period counted in enabled cycles plus a one-slot buffer
   int unsigned m_run   [2];
   int unsigned m_phase [2];
   logic        m_valid [2];
   logic [15:0] m_data  [2];
   logic        m_ovr   [2];
   int unsigned rdiv    [2];

   function automatic logic [15:0] wave(input logic [1:0] md, input int unsigned p, input logic [15:0] lvl);
      case (md)
         2'd0:    return 16'(p);
         2'd1:    return (p < 32768) ? 16'(2 * p) : 16'(65535 - 2 * (p - 32768));
         2'd2:    return (p < 32768) ? 16'hFFFF : 16'h0000;
         default: return lvl;
      endcase
   endfunction

   task automatic model_update();
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_run[k] = 0; m_phase[k] = 0; m_valid[k] = 1'b0; m_data[k] = 16'h0; m_ovr[k] = 1'b0;
         end else begin
            logic tick, set;
            tick = en && ((m_run[k] % rdiv[k]) == rdiv[k] - 1);
            m_run[k] = en ? m_run[k] + 1 : 0;
            set = 1'b0;
            if (tick) begin
               logic [15:0] s;
               s = wave(mode, m_phase[k] / 256, const_level);
               m_phase[k] = (m_phase[k] + int'(phase_inc)) % (1 << 24);
               if (!m_valid[k] || ready) begin
                  m_data[k] = s; m_valid[k] = 1'b1;
               end else set = 1'b1;
            end else if (m_valid[k] && ready) begin
               m_valid[k] = 1'b0;
            end
            if (set) m_ovr[k] = 1'b1;
            else if (clr_overrun) m_ovr[k] = 1'b0;
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      chk("model_valid_r4", 32'(v0), 32'(m_valid[0]));
      chk("model_data_r4",  32'(d0), 32'(m_data[0]));
      chk("model_ovr_r4",   32'(o0), 32'(m_ovr[0]));
      chk("model_valid_r1", 32'(v1), 32'(m_valid[1]));
      chk("model_data_r1",  32'(d1), 32'(m_data[1]));
      chk("model_ovr_r1",   32'(o1), 32'(m_ovr[1]));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic wait_valid(input string name, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 12 && !ok; i++) begin
         step();
         if (v0) ok = 1'b1;
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL %s actual=timeout required=valid", name);
      end
   endtask

   typedef struct {
      logic [1:0]  mode;
      logic [23:0] inc;
      logic [15:0] lvl;
      int          idx;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl[$];

   initial begin
      logic ok;
      rdiv[0] = 4; rdiv[1] = 1;
      rst = 1'b1; en = 1'b0; mode = 2'd0; phase_inc = 24'h0; const_level = 16'h0;
      clr_overrun = 1'b0; ready = 1'b0;

      // Reset then idle with the pacer disabled
      repeat (3) step();
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (i % 25 == 0) begin
            chk("t1_valid", 32'(v0), 32'h0);
            chk("t1_data", 32'(d0), 32'h0);
            chk("t1_ovr", 32'(o0), 32'h0);
         end
      end

      // Waveform table: n-th emitted sample after reset
      tbl.push_back('{2'd0, 24'h010000, 16'h0, 0,   16'h0000});
      tbl.push_back('{2'd0, 24'h010000, 16'h0, 1,   16'h0100});
      tbl.push_back('{2'd0, 24'h010000, 16'h0, 255, 16'hFF00});
      tbl.push_back('{2'd0, 24'h010000, 16'h0, 256, 16'h0000});
      tbl.push_back('{2'd1, 24'h200000, 16'h0, 0,   16'h0000});
      tbl.push_back('{2'd1, 24'h200000, 16'h0, 1,   16'h4000});
      tbl.push_back('{2'd1, 24'h200000, 16'h0, 2,   16'h8000});
      tbl.push_back('{2'd1, 24'h200000, 16'h0, 3,   16'hC000});
      tbl.push_back('{2'd1, 24'h200000, 16'h0, 4,   16'hFFFF});
      tbl.push_back('{2'd1, 24'h200000, 16'h0, 5,   16'hBFFF});
      tbl.push_back('{2'd1, 24'h200000, 16'h0, 6,   16'h7FFF});
      tbl.push_back('{2'd1, 24'h200000, 16'h0, 7,   16'h3FFF});
      tbl.push_back('{2'd1, 24'h200000, 16'h0, 8,   16'h0000});
      tbl.push_back('{2'd2, 24'h400000, 16'h0, 1,   16'hFFFF});
      tbl.push_back('{2'd2, 24'h400000, 16'h0, 2,   16'h0000});
      tbl.push_back('{2'd2, 24'h400000, 16'h0, 4,   16'hFFFF});
      tbl.push_back('{2'd3, 24'h123456, 16'h1234, 3, 16'h1234});
      foreach (tbl[i]) begin
         int cnt;
         logic found;
         mode = tbl[i].mode; phase_inc = tbl[i].inc; const_level = tbl[i].lvl;
         ready = 1'b1; en = 1'b0;
         do_reset();
         en = 1'b1;
         cnt = 0; found = 1'b0;
         for (int s = 0; s < (tbl[i].idx + 2) * 4 + 8 && !found; s++) begin
            step();
            chk("tbl_ovr", 32'(o0), 32'h0);
            if (v0) begin
               if (cnt == tbl[i].idx) begin
                  chk($sformatf("tbl%0d_data", i), 32'(d0), 32'(tbl[i].exp));
                  found = 1'b1;
               end
               cnt++;
            end
         end
         if (!found) begin
            checks++; errors++;
            $display("FAIL tbl%0d_timeout actual=%0d required=%0d samples", i, cnt, tbl[i].idx + 1);
         end
      end

      // Backpressure: ten ticks with ready low
      mode = 2'd0; phase_inc = 24'h010000; ready = 1'b0; en = 1'b0;
      do_reset();
      en = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (i == 4) chk("bp_ovr_tick1", 32'(o0), 32'h0);
         if (i == 8) chk("bp_ovr_tick2", 32'(o0), 32'h1);
      end
      chk("bp_hold_data", 32'(d0), 32'h0000);
      chk("bp_hold_valid", 32'(v0), 32'h1);
      chk("bp_ovr", 32'(o0), 32'h1);
      ready = 1'b1;
      step();
      chk("bp_drain", 32'(v0), 32'h0);
      wait_valid("bp_next_timeout", ok);
      if (ok) chk("bp_next_data", 32'(d0), 32'h0A00);
      clr_overrun = 1'b1;
      step();
      clr_overrun = 1'b0;
      chk("bp_clr", 32'(o0), 32'h0);

      // Full rate instance: new sample every enabled clock
      mode = 2'd0; phase_inc = 24'h010000; ready = 1'b1; en = 1'b0;
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("full_valid", 32'(v1), 32'h1);
         chk("full_data", 32'(d1), 32'(16'(i * 256)));
         chk("full_ovr", 32'(o1), 32'h0);
      end

      // Mid-operation reset with a pending sample, then en drop timing
      ready = 1'b0; en = 1'b0;
      do_reset();
      en = 1'b1;
      repeat (6) step();
      chk("mr_pending", 32'(v0), 32'h1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mr_valid", 32'(v0), 32'h0);
      chk("mr_data", 32'(d0), 32'h0);
      ready = 1'b1;
      wait_valid("mr_restart_timeout", ok);
      if (ok) chk("mr_first", 32'(d0), 32'h0000);
      en = 1'b0;
      repeat (7) step();
      en = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         step();
         if (i < 4) chk("en_early", 32'(v0), 32'h0);
         if (i == 4) chk("en_tick", 32'(v0), 32'h1);
      end

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         rst         = ($urandom_range(127) == 0);
         en          = ($urandom_range(15) != 0);
         if ($urandom_range(31) == 0) mode = 2'($urandom);
         if ($urandom_range(15) == 0) phase_inc = 24'($urandom);
         const_level = 16'($urandom);
         ready       = ($urandom_range(2) != 0);
         clr_overrun = ($urandom_range(19) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
